// File: rtl/decode_prefix_scan.sv
// Legacy-prefix and 0x0F-escape scanner. It walks the raw 15-byte window one byte per
// cycle and hands the opcode-aligned 9-byte window plus prefix state downstream.
module decode_prefix_scan #(
  parameter int unsigned MAX_PREFIXES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [119:0] raw_instr,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [71:0]  unescaped_instr,
  output logic         is_2byte,
  output logic [3:0]   prefix_count,
  output logic         opsize_ovr,
  output logic         addrsize_ovr,
  output logic         lock,
  output logic [1:0]   rep,
  output logic [2:0]   seg_ovr,
  output logic         err_prefix,
  output logic         err_truncated
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t       state;
  logic [119:0] buffer;
  logic [3:0]   idx;
  logic [71:0]  window;
  logic [7:0]   cur_byte;
  logic         is_pfx;
  logic         pfx_full;

  // idx == 15 shifts the whole buffer out, which yields the zero window on truncation
  assign window   = 72'(buffer >> {idx, 3'b000});
  assign cur_byte = window[7:0];
  assign pfx_full = (prefix_count == 4'(MAX_PREFIXES));
  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);

  always_comb begin
    is_pfx = 1'b0;
    if (!is_2byte) begin
      case (cur_byte)
        8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
        8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3: is_pfx = 1'b1;
        default: is_pfx = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      buffer          <= '0;
      idx             <= '0;
      out_valid       <= 1'b0;
      unescaped_instr <= '0;
      is_2byte        <= 1'b0;
      prefix_count    <= '0;
      opsize_ovr      <= 1'b0;
      addrsize_ovr    <= 1'b0;
      lock            <= 1'b0;
      rep             <= '0;
      seg_ovr         <= '0;
      err_prefix      <= 1'b0;
      err_truncated   <= 1'b0;
    end else if (in_valid && in_ready) begin
      state         <= SCAN;
      buffer        <= raw_instr;
      idx           <= '0;
      out_valid     <= 1'b0;
      is_2byte      <= 1'b0;
      prefix_count  <= '0;
      opsize_ovr    <= 1'b0;
      addrsize_ovr  <= 1'b0;
      lock          <= 1'b0;
      rep           <= '0;
      seg_ovr       <= '0;
      err_prefix    <= 1'b0;
      err_truncated <= 1'b0;
    end else begin
      case (state)
        SCAN: begin
          if (idx == 4'd15) begin
            err_truncated   <= 1'b1;
            unescaped_instr <= window;
            out_valid       <= 1'b1;
            state           <= DONE;
          end else if (is_pfx && pfx_full) begin
            err_prefix      <= 1'b1;
            unescaped_instr <= window;
            out_valid       <= 1'b1;
            state           <= DONE;
          end else if (is_pfx) begin
            prefix_count <= prefix_count + 4'd1;
            idx          <= idx + 4'd1;
            case (cur_byte)
              8'h66:   opsize_ovr   <= 1'b1;
              8'h67:   addrsize_ovr <= 1'b1;
              8'hF0:   lock         <= 1'b1;
              8'hF3:   rep          <= 2'b01;
              8'hF2:   rep          <= 2'b10;
              8'h26:   seg_ovr      <= 3'd1;
              8'h2E:   seg_ovr      <= 3'd2;
              8'h36:   seg_ovr      <= 3'd3;
              8'h3E:   seg_ovr      <= 3'd4;
              8'h64:   seg_ovr      <= 3'd5;
              8'h65:   seg_ovr      <= 3'd6;
              default: ;
            endcase
          end else if ((cur_byte == 8'h0F) && !is_2byte) begin
            is_2byte <= 1'b1;
            idx      <= idx + 4'd1;
          end else begin
            unescaped_instr <= window;
            out_valid       <= 1'b1;
            state           <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_decode_prefix_scan.sv
// Bench for decode_prefix_scan: table-driven back-to-back stream with a scoreboard,
// plus reset-mid-scan and long-window sequences on a MAX_PREFIXES=14 instance.
module tb_decode_prefix_scan;

  typedef struct {
    logic [119:0] raw;
    logic [71:0]  unesc;
    logic         is2;
    logic [3:0]   cnt;
    logic         opsz;
    logic         adsz;
    logic         lck;
    logic [1:0]   rp;
    logic [2:0]   seg;
    logic         errp;
    logic         errt;
    int           lat;
    int           stall;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [119:0] raw_instr = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [71:0]  unescaped_instr;
  logic         is_2byte;
  logic [3:0]   prefix_count;
  logic         opsize_ovr, addrsize_ovr, lock, err_prefix, err_truncated;
  logic [1:0]   rep;
  logic [2:0]   seg_ovr;

  logic         in_valid14 = 1'b0;
  logic         in_ready14;
  logic [119:0] raw14 = '0;
  logic         out_valid14;
  logic         out_ready14 = 1'b1;
  logic [71:0]  unesc14;
  logic         is2_14, opsz14, adsz14, lock14, errp14, errt14;
  logic [3:0]   cnt14;
  logic [1:0]   rep14;
  logic [2:0]   seg14;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int hs_cyc = 0;
  vec_t exp_q[$];
  int   acc_q[$];
  vec_t vec[10];

  decode_prefix_scan dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .raw_instr(raw_instr),
    .out_valid(out_valid), .out_ready(out_ready), .unescaped_instr(unescaped_instr),
    .is_2byte(is_2byte), .prefix_count(prefix_count), .opsize_ovr(opsize_ovr),
    .addrsize_ovr(addrsize_ovr), .lock(lock), .rep(rep), .seg_ovr(seg_ovr),
    .err_prefix(err_prefix), .err_truncated(err_truncated)
  );

  decode_prefix_scan #(.MAX_PREFIXES(14)) dut14 (
    .clk(clk), .rst(rst), .in_valid(in_valid14), .in_ready(in_ready14), .raw_instr(raw14),
    .out_valid(out_valid14), .out_ready(out_ready14), .unescaped_instr(unesc14),
    .is_2byte(is2_14), .prefix_count(cnt14), .opsize_ovr(opsz14),
    .addrsize_ovr(adsz14), .lock(lock14), .rep(rep14), .seg_ovr(seg14),
    .err_prefix(errp14), .err_truncated(errt14)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [119:0] raw, input logic [71:0] unesc,
                              input logic is2, input logic [3:0] cnt, input logic opsz,
                              input logic adsz, input logic lck, input logic [1:0] rp,
                              input logic [2:0] seg, input logic errp, input logic errt,
                              input int lat, input int stall);
    vec_t v;
    v.raw = raw; v.unesc = unesc; v.is2 = is2; v.cnt = cnt; v.opsz = opsz;
    v.adsz = adsz; v.lck = lck; v.rp = rp; v.seg = seg; v.errp = errp;
    v.errt = errt; v.lat = lat; v.stall = stall;
    return v;
  endfunction

  task automatic cmp_out(input vec_t e);
    chk("unescaped", unescaped_instr, e.unesc);
    chk("is_2byte", is_2byte, e.is2);
    chk("prefix_count", prefix_count, e.cnt);
    chk("opsize_ovr", opsize_ovr, e.opsz);
    chk("addrsize_ovr", addrsize_ovr, e.adsz);
    chk("lock", lock, e.lck);
    chk("rep", rep, e.rp);
    chk("seg_ovr", seg_ovr, e.seg);
    chk("err_prefix", err_prefix, e.errp);
    chk("err_truncated", err_truncated, e.errt);
  endtask

  // Monitor: owns out_ready, applies per-vector stalls, pops on handshake.
  initial begin : monitor
    bit seen = 0;
    int vstart = 0;
    int stall_left = 0;
    forever begin
      @(negedge clk);
      #1;
      out_ready = 1'b1;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", out_valid, 1'b0);
        end else begin
          if (!seen) begin
            seen = 1; vstart = cyc; stall_left = exp_q[0].stall;
          end
          cmp_out(exp_q[0]);
          if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            chk("latency", vstart - acc_q[0], exp_q[0].lat);
            hs_cyc = cyc + 1;
            void'(exp_q.pop_front());
            void'(acc_q.pop_front());
            seen = 0;
          end
        end
      end
    end
  end

  task automatic run14(input string nm, input logic [119:0] raw, input vec_t e);
    int a;
    int w = 0;
    @(negedge clk);
    raw14 = raw;
    in_valid14 = 1'b1;
    @(posedge clk);
    #1;
    a = cyc;
    @(negedge clk);
    in_valid14 = 1'b0;
    while (!out_valid14 && w < 40) begin
      @(posedge clk);
      #1;
      w++;
    end
    chk({nm, "_valid"}, out_valid14, 1'b1);
    chk({nm, "_latency"}, cyc - a, e.lat);
    chk({nm, "_unescaped"}, unesc14, e.unesc);
    chk({nm, "_is_2byte"}, is2_14, e.is2);
    chk({nm, "_count"}, cnt14, e.cnt);
    chk({nm, "_opsize"}, opsz14, e.opsz);
    chk({nm, "_err_prefix"}, errp14, e.errp);
    chk({nm, "_err_trunc"}, errt14, e.errt);
    @(posedge clk);
    #1;
    chk({nm, "_valid_drop"}, out_valid14, 1'b0);
  endtask

  initial begin : driver
    int w;
    bit accepted;
    vec[0] = mk(120'h90, 72'h90, 0, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 1, 0);
    vec[1] = mk(120'hC1AF0F66, 72'hC1AF, 1, 1, 1, 0, 0, 2'd0, 3'd0, 0, 0, 3, 3);
    vec[2] = mk(120'hA4642EF2F3, 72'hA4, 0, 4, 0, 0, 0, 2'd2, 3'd5, 0, 0, 5, 0);
    vec[3] = mk(120'h8B3EF326F067, 72'h8B3E, 0, 4, 0, 1, 1, 2'd1, 3'd1, 1, 0, 5, 0);
    vec[4] = mk(120'h050F0F, 72'h050F, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 2, 0);
    vec[5] = mk(120'hC1660F, 72'hC166, 1, 0, 0, 0, 0, 2'd0, 3'd0, 0, 0, 2, 0);
    vec[6] = mk(120'h9036656666, 72'h90, 0, 4, 1, 0, 0, 2'd0, 3'd3, 0, 0, 5, 0);
    vec[7] = mk(120'h0E0D0C0B0A0908070605040302012E, 72'h090807060504030201,
                0, 1, 0, 0, 0, 2'd0, 3'd2, 0, 0, 2, 0);
    vec[8] = mk({15{8'h66}}, {9{8'h66}}, 0, 4, 1, 0, 0, 2'd0, 3'd0, 1, 0, 5, 10);
    vec[9] = mk(120'h380FF2F0, 72'h38, 1, 2, 0, 0, 1, 2'd2, 3'd0, 0, 0, 4, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_unescaped", unescaped_instr, 72'h0);
    chk("reset_count", prefix_count, 4'd0);
    chk("reset_flags", {is_2byte, opsize_ovr, addrsize_ovr, lock, rep, seg_ovr,
                        err_prefix, err_truncated}, 11'h0);

    // Back-to-back stream: in_valid stays high between vectors.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      raw_instr = vec[i].raw;
      accepted = 0;
      w = 0;
      while (!accepted && w < 100) begin
        #2;
        if (in_ready) begin
          @(posedge clk);
          #1;
          exp_q.push_back(vec[i]);
          acc_q.push_back(cyc);
          if (i > 0) chk("back_to_back_edge", cyc, hs_cyc);
          accepted = 1;
        end else begin
          @(negedge clk);
          w++;
        end
      end
      chk("accept_timeout", accepted, 1'b1);
    end
    @(negedge clk);
    in_valid = 1'b0;

    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    chk("drain", exp_q.size(), 0);
    repeat (2) @(posedge clk);

    // Reset mid-scan drops the instruction silently.
    @(negedge clk);
    raw_instr = 120'h9066666666;
    in_valid = 1'b1;
    #2;
    chk("idle_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midscan_rst_out_valid", out_valid, 1'b0);
    chk("midscan_rst_in_ready", in_ready, 1'b1);
    chk("midscan_rst_count", prefix_count, 4'd0);
    chk("midscan_rst_opsize", opsize_ovr, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    chk("midscan_rst_no_output", out_valid, 1'b0);

    run14("trunc", {8'h0F, {14{8'h66}}},
          mk('0, 72'h0, 1, 14, 1, 0, 0, 2'd0, 3'd0, 0, 1, 16, 0));
    run14("max14", {15{8'h66}},
          mk('0, 72'h66, 0, 14, 1, 0, 0, 2'd0, 3'd0, 1, 0, 15, 0));
    run14("zerofill", {8'h44, 8'h33, 8'h22, 8'h11, 8'h90, {10{8'h66}}},
          mk('0, 72'h4433221190, 0, 10, 1, 0, 0, 2'd0, 3'd0, 0, 0, 11, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
